btn_repeat_pulser: RTL and testbench

Conditions one raw push-button input for the time-setting logic of the digital clock. Each instance sits between a board button pin and the hour/minute increment logic. Per instance it:
- synchronises the raw button into the CLK100MHZ domain;
- debounces it with a stable-count filter;
- emits a single-cycle increment pulse on each accepted press;
- optionally emits further pulses at a fixed rate while the button is held.

---
 rtl/btn_repeat_pulser.sv | 148 ++++++++++++++
 tb/tb_btn_repeat_pulser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_repeat_pulser.sv
// Push-button conditioner: 2-flop synchroniser, stable-count debounce, press pulse
// and optional hold-to-repeat pulses (enabled by defining BTN_AUTOREPEAT_EN).
module btn_repeat_pulser #(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 50000000,
    parameter int REPEAT_PERIOD_CYCLES = 20000000,
    parameter int CNT_W                = 26
) (
    input  logic CLK100MHZ,
    input  logic Reset,
    input  logic BTN_raw,
    output logic BTN_level,
    output logic BTN_pulse
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_TC   = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [CNT_W-1:0] r_rcnt;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1
    } state_t;
`endif

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_dcnt;
    state_t           r_state;

    logic             w_differ;
    logic             w_accept;
    logic             w_level_nxt;

    // The FSM reacts to the level being accepted this cycle, so the press pulse
    // lines up with BTN_level and a release can never coincide with a repeat.
    assign w_differ    = (r_sync2 != r_level);
    assign w_accept    = w_differ && (r_dcnt == DB_TC);
    assign w_level_nxt = w_accept ? r_sync2 : r_level;

    assign BTN_level   = r_level;
    assign BTN_pulse   = r_pulse;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= BTN_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stable-count debounce: a level change needs DEBOUNCE_CYCLES disagreeing samples.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            r_dcnt  <= CNT_ZERO;
            r_level <= 1'b0;
        end else if (!w_differ) begin
            r_dcnt  <= CNT_ZERO;
        end else if (w_accept) begin
            r_dcnt  <= CNT_ZERO;
            r_level <= r_sync2;
        end else begin
            r_dcnt  <= r_dcnt + CNT_ONE;
        end
    end

    // Press state machine with registered pulse output.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt  <= CNT_ZERO;
`endif
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_level_nxt && !r_level) begin
                        r_pulse <= 1'b1;
                        r_state <= ST_HELD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    r_rcnt <= CNT_ZERO;
`endif
                end
                ST_HELD: begin
                    if (!w_level_nxt) begin
                        r_state <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                        r_rcnt  <= CNT_ZERO;
                    end else if (r_rcnt == DLY_TC) begin
                        r_pulse <= 1'b1;
                        r_rcnt  <= CNT_ZERO;
                        r_state <= ST_REPEAT;
                    end else begin
                        r_rcnt  <= r_rcnt + CNT_ONE;
`else
                    end else begin
`endif
                        r_state <= ST_HELD;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (!w_level_nxt) begin
                        r_state <= ST_IDLE;
                        r_rcnt  <= CNT_ZERO;
                    end else if (r_rcnt == PER_TC) begin
                        r_pulse <= 1'b1;
                        r_rcnt  <= CNT_ZERO;
                        r_state <= ST_REPEAT;
                    end else begin
                        r_rcnt  <= r_rcnt + CNT_ONE;
                        r_state <= ST_REPEAT;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    r_rcnt  <= CNT_ZERO;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_repeat_pulser.sv
// Scoreboard bench for btn_repeat_pulser: a window-based reference model pushes
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_btn_repeat_pulser;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic raw;
    logic level;
    logic pulse;

    always #5 clk = ~clk;

    btn_repeat_pulser #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .CNT_W                (26)
    ) dut (
        .CLK100MHZ (clk),
        .Reset     (rst_n),
        .BTN_raw   (raw),
        .BTN_level (level),
        .BTN_pulse (pulse)
    );

    typedef struct packed {
        logic lvl;
        logic pls;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    int   dut_pulses = 0;

    // Reference model state: raw samples since reset, last D synchronised samples.
    bit   hist_raw[$];
    bit   win[$];
    bit   m_level;
    bit   m_pulse;
    int   cyc;
    int   press_edge;

    task automatic model_clear();
        hist_raw.delete();
        win.delete();
        m_level    = 1'b0;
        m_pulse    = 1'b0;
        press_edge = -1000000;
    endtask

    // Called just after a rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit s;
        bit all_diff;
        bit old;
        int age;
        if (!rst_n) begin
            model_clear();
        end else begin
            hist_raw.push_back(raw);
            s = (hist_raw.size() >= 3) ? hist_raw[hist_raw.size()-3] : 1'b0;
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            all_diff = (win.size() == D);
            foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
            old = m_level;
            if (all_diff) m_level = ~m_level;
            if (!old && m_level) press_edge = cyc;
            age = cyc - press_edge;
            m_pulse = m_level && ((age == 0) ||
                      (AR && age >= RD && ((age - RD) % RP) == 0));
        end
        cyc++;
    endtask

    task automatic cycle(input logic r, input logic rs);
        exp_t e;
        @(posedge clk);
        model_edge();
        #2;
        raw   = r;
        rst_n = rs;
        if (!rs) model_clear();
        e.lvl = m_level;
        e.pls = m_pulse;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic run(input logic r, input int n);
        for (int i = 0; i < n; i++) cycle(r, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents level/pulse; compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pulse === 1'b1) dut_pulses++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: no expected entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (level === e.lvl) passed++;
                else $display("FAIL level: got %0b expected %0b at t=%0t", level, e.lvl, $time);
                total++;
                if (pulse === e.pls) passed++;
                else $display("FAIL pulse: got %0b expected %0b at t=%0t", pulse, e.pls, $time);
            end
        end
    end

    initial begin
        int p0;
        int len;
        logic lv;
        rst_n = 1'b0;
        raw   = 1'b0;
        cyc   = 0;
        model_clear();

        // Reset held with the button toggling.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        run(1'b0, 6);

        // Clean press held 12 cycles.
        run(1'b1, 12);
        run(1'b0, 15);

        // Bounce pattern shorter than the debounce window.
        run(1'b1, 1); run(1'b0, 1); run(1'b1, 2); run(1'b0, 12);

        // Long hold: count pulses, expected count fixed by the repeat timing.
        p0 = dut_pulses;
        run(1'b1, 60);
        run(1'b0, 20);
        @(negedge clk);
        #1;
        total++;
        if ((dut_pulses - p0) == (AR ? 6 : 1)) passed++;
        else $display("FAIL long_hold_count: got %0d pulses expected %0d",
                      dut_pulses - p0, AR ? 6 : 1);

        // Reset mid-hold with the button still pressed.
        run(1'b1, 30);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        run(1'b1, 40);
        run(1'b0, 15);

        // Randomised holds, glitches and occasional resets.
        lv = 1'b0;
        for (int k = 0; k < 150; k++) begin
            lv  = ~lv;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D-1) : $urandom_range(D, 45);
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < $urandom_range(1, 3); j++) cycle(lv, 1'b0);
            end
            run(lv, len);
        end
        run(1'b0, 15);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
